// File: rtl/count_pkg.sv
// Shared definitions for the count_monitor block: FSM state encoding,
// default observed-count width and the counter direction encoding.
package count_pkg;

  localparam int WIDTH_DEF = 4;

  typedef enum logic [1:0] {
    ST_SYNC  = 2'd0,
    ST_TRACK = 2'd1,
    ST_FAULT = 2'd2
  } state_e;

  localparam logic CTL_UP   = 1'b0;
  localparam logic CTL_DOWN = 1'b1;

endpackage

// File: rtl/count_monitor_if.sv
// Observation bundle between the counter side (master) and the monitor
// (slave). The master owns control/count; the monitor owns all results.
interface count_monitor_if import count_pkg::*; #(
  parameter int WIDTH = WIDTH_DEF,
  parameter int ERR_W = 8
);

  logic             control;
  logic [WIDTH-1:0] count;
  logic [WIDTH-1:0] expected;
  logic             locked;
  logic             err;
  logic [ERR_W-1:0] err_count;
  logic             wrap_up;
  logic             wrap_down;
  logic             fault;

  modport master (
    output control, count,
    input  expected, locked, err, err_count, wrap_up, wrap_down, fault
  );

  modport slave (
    input  control, count,
    output expected, locked, err, err_count, wrap_up, wrap_down, fault
  );

endinterface

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         nrst,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q;

  // advance on enable unless already saturated
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      cnt_q <= '0;
    end else if (inc_i && (cnt_q != {W{1'b1}})) begin
      cnt_q <= cnt_q + W'(1);
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/count_monitor.sv
// Passive checker for a WIDTH-bit up/down counter. Predicts the next count
// from the last sampled count/direction, flags and tallies mismatches,
// reports wraps and latches a sticky fault after MAX_CONSEC errors in a row.
//
//   state    | meaning
//   ---------+---------------------------------------------------------
//   ST_SYNC  | first edge after reset: capture count/control, no check
//   ST_TRACK | compare every edge, resync by capturing observed value
//   ST_FAULT | sticky fault; still compares and tallies, no wrap pulses
module count_monitor import count_pkg::*; #(
  parameter int WIDTH      = WIDTH_DEF,
  parameter int ERR_W      = 8,
  parameter int MAX_CONSEC = 3
) (
  input  logic            clk,
  input  logic            nrst,
  count_monitor_if.slave  mon
);

  localparam logic [WIDTH-1:0] CNT_MAX    = {WIDTH{1'b1}};
  localparam logic [3:0]       CONSEC_LIM = 4'(MAX_CONSEC);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] cnt_q;
  logic             ctl_q;
  logic [3:0]       consec_q, consec_d;
  logic             err_q, err_d;
  logic             wrap_up_q, wrap_up_d;
  logic             wrap_down_q, wrap_down_d;
  logic [WIDTH-1:0] pred;
  logic             mismatch;
  logic [3:0]       consec_inc;

  // next count implied by last sample, modulo 2^WIDTH
  always_comb begin
    if (ctl_q == CTL_DOWN) begin
      pred = cnt_q - WIDTH'(1);
    end else begin
      pred = cnt_q + WIDTH'(1);
    end
  end

  assign mismatch   = (state_q != ST_SYNC) && (mon.count != pred);
  assign consec_inc = consec_q + 4'd1;

  // FSM next state and per-edge result flags
  always_comb begin
    state_d     = state_q;
    consec_d    = consec_q;
    err_d       = 1'b0;
    wrap_up_d   = 1'b0;
    wrap_down_d = 1'b0;
    case (state_q)
      ST_SYNC: begin
        consec_d = '0;
        state_d  = ST_TRACK;
      end
      ST_TRACK: begin
        if (mismatch) begin
          err_d    = 1'b1;
          consec_d = consec_inc;
          if (consec_inc >= CONSEC_LIM) begin
            state_d = ST_FAULT;
          end
        end else begin
          consec_d    = '0;
          wrap_up_d   = (ctl_q == CTL_UP) && (cnt_q == CNT_MAX) &&
                        (mon.count == '0);
          wrap_down_d = (ctl_q == CTL_DOWN) && (cnt_q == '0) &&
                        (mon.count == CNT_MAX);
        end
      end
      ST_FAULT: begin
        // consec is irrelevant once faulted; only the tally keeps moving
        err_d = mismatch;
      end
      default: begin
        state_d = ST_SYNC;
      end
    endcase
  end

  // state, sample capture and registered result pulses
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q     <= ST_SYNC;
      cnt_q       <= '0;
      ctl_q       <= 1'b0;
      consec_q    <= '0;
      err_q       <= 1'b0;
      wrap_up_q   <= 1'b0;
      wrap_down_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= mon.count;
      ctl_q       <= mon.control;
      consec_q    <= consec_d;
      err_q       <= err_d;
      wrap_up_q   <= wrap_up_d;
      wrap_down_q <= wrap_down_d;
    end
  end

  sat_counter #(
    .W (ERR_W)
  ) u_err_cnt (
    .clk   (clk),
    .nrst  (nrst),
    .inc_i (err_d),
    .cnt_o (mon.err_count)
  );

  assign mon.expected  = (state_q == ST_SYNC) ? cnt_q : pred;
  assign mon.locked    = (state_q == ST_TRACK);
  assign mon.fault     = (state_q == ST_FAULT);
  assign mon.err       = err_q;
  assign mon.wrap_up   = wrap_up_q;
  assign mon.wrap_down = wrap_down_q;

endmodule

// File: tb/tb_count_monitor.sv
// Scoreboard bench for count_monitor: a reference counter drives count,
// a spec-level model predicts each edge's results into a queue, and a
// monitor process pops and compares one entry per clock edge.
module tb_count_monitor;
  import count_pkg::*;

  localparam int W  = 4;
  localparam int EW = 8;
  localparam int MC = 3;

  typedef struct {
    int err;
    int wu;
    int wd;
    int ec;
    int flt;
    int lck;
    int ex;
  } exp_t;

  logic clk  = 1'b0;
  logic nrst = 1'b0;
  always #5 clk = ~clk;

  count_monitor_if #(.WIDTH(W), .ERR_W(EW)) mif ();

  count_monitor #(
    .WIDTH      (W),
    .ERR_W      (EW),
    .MAX_CONSEC (MC)
  ) dut (
    .clk  (clk),
    .nrst (nrst),
    .mon  (mif)
  );

  // reference up/down counter sharing clk/nrst with the monitor
  logic [3:0] ref_cnt;
  always @(posedge clk or negedge nrst) begin
    if (!nrst) ref_cnt <= 4'd0;
    else       ref_cnt <= mif.control ? ref_cnt - 4'd1 : ref_cnt + 4'd1;
  end

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;

  // model state
  bit m_sync, m_fault;
  int m_last, m_lctl, m_consec, m_errs;

  function automatic int next_of(input int v, input int d);
    return (v + (d != 0 ? 15 : 1)) % 16;
  endfunction

  task automatic chk(input string nm, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s cycle=%0d actual=%0d required=%0d", nm, cyc, act, req);
    end
  endtask

  task automatic model_reset();
    m_sync   = 1'b0;
    m_fault  = 1'b0;
    m_last   = 0;
    m_lctl   = 0;
    m_consec = 0;
    m_errs   = 0;
  endtask

  // present inputs for the next edge, predict its outcome, advance a cycle
  task automatic drive(input int ctl, input bit frc, input int fv);
    int   c;
    exp_t e;
    c = frc ? fv : int'(ref_cnt);
    mif.control = ctl[0];
    mif.count   = c[3:0];
    e = '{default: 0};
    if (!m_sync) begin
      m_sync = 1'b1;
    end else if (c != next_of(m_last, m_lctl)) begin
      e.err = 1;
      if (m_errs < 255) m_errs++;
      if (!m_fault) begin
        m_consec++;
        if (m_consec >= MC) m_fault = 1'b1;
      end
    end else begin
      m_consec = 0;
      if (!m_fault) begin
        e.wu = (m_last == 15 && c == 0 && m_lctl == 0) ? 1 : 0;
        e.wd = (m_last == 0 && c == 15 && m_lctl == 1) ? 1 : 0;
      end
    end
    m_last = c;
    m_lctl = ctl;
    e.ec  = m_errs;
    e.flt = m_fault ? 1 : 0;
    e.lck = (m_sync && !m_fault) ? 1 : 0;
    e.ex  = next_of(m_last, m_lctl);
    q.push_back(e);
    @(posedge clk);
    #2;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_err"},       int'(mif.err),       0);
    chk({tag, "_wrap_up"},   int'(mif.wrap_up),   0);
    chk({tag, "_wrap_down"}, int'(mif.wrap_down), 0);
    chk({tag, "_err_count"}, int'(mif.err_count), 0);
    chk({tag, "_fault"},     int'(mif.fault),     0);
    chk({tag, "_locked"},    int'(mif.locked),    0);
    chk({tag, "_expected"},  int'(mif.expected),  0);
  endtask

  // asynchronous reset pulse of 3 ns between clock edges
  task automatic reset_pulse();
    nrst = 1'b0;
    #1;
    check_all_zero("async_rst");
    #2;
    nrst = 1'b1;
    model_reset();
  endtask

  // monitor: one expected entry per clock edge once stimulus is running
  always @(posedge clk) begin
    exp_t e;
    #1;
    cyc++;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("err",       int'(mif.err),       e.err);
      chk("wrap_up",   int'(mif.wrap_up),   e.wu);
      chk("wrap_down", int'(mif.wrap_down), e.wd);
      chk("err_count", int'(mif.err_count), e.ec);
      chk("fault",     int'(mif.fault),     e.flt);
      chk("locked",    int'(mif.locked),    e.lck);
      chk("expected",  int'(mif.expected),  e.ex);
    end
  end

  initial begin
    int ctl;
    mif.control = 1'b0;
    mif.count   = 4'd0;
    model_reset();
    #2;
    check_all_zero("reset");
    #6;
    nrst = 1'b1;

    // free-running up count through a 15 -> 0 wrap
    repeat (20) drive(0, 1'b0, 0);

    // count down from 2 through a 0 -> 15 wrap
    for (int i = 0; i < 32 && ref_cnt != 4'd2; i++) drive(0, 1'b0, 0);
    repeat (5) drive(1, 1'b0, 0);

    // single glitch 9 where 5 is due, then counter carries on
    for (int i = 0; i < 32 && ref_cnt != 4'd5; i++) drive(0, 1'b0, 0);
    drive(0, 1'b1, 9);
    repeat (3) drive(0, 1'b0, 0);

    // stuck count of 7 drives the monitor into FAULT, which must stick
    for (int i = 0; i < 32 && ref_cnt != 4'd0; i++) drive(0, 1'b0, 0);
    repeat (4) drive(0, 1'b1, 7);
    repeat (5) drive(0, 1'b0, 0);

    // guaranteed mismatches until err_count saturates
    repeat (300) begin
      ctl = int'($urandom_range(0, 1));
      drive(ctl, 1'b1, (next_of(m_last, m_lctl) + 3) % 16);
    end
    repeat (10) drive(int'($urandom_range(0, 1)), 1'b0, 0);

    // mid-count asynchronous reset, then resync
    reset_pulse();
    repeat (3) drive(0, 1'b0, 0);

    // random direction with frequent glitches
    repeat (200) begin
      ctl = int'($urandom_range(0, 1));
      if ($urandom_range(0, 9) == 0) drive(ctl, 1'b1, int'($urandom_range(0, 15)));
      else                           drive(ctl, 1'b0, 0);
    end

    // random direction with rare glitches after a fresh reset
    reset_pulse();
    repeat (150) begin
      ctl = int'($urandom_range(0, 1));
      if ($urandom_range(0, 39) == 0) drive(ctl, 1'b1, int'($urandom_range(0, 15)));
      else                            drive(ctl, 1'b0, 0);
    end

    repeat (2) @(posedge clk);
    #3;
    chk("queue_drained", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
